mem_loader_bus: RTL and testbench

//  Memory subsystem on the CPU's memory side: 256x8 RAM with async read and sync write.

---
 rtl/mem_sys_pkg.sv | 15 +
 rtl/ram256x8.sv | 21 ++
 rtl/mem_loader_bus.sv | 153 +++++++++++++++
 tb/tb_mem_loader_bus.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - loader FSM state encoding and memory-map defaults
package mem_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [7:0] IO_ADRS_DEF    = 8'hFF;
    localparam logic [7:0] PROT_LIMIT_DEF = 8'h40;
    localparam int         SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ram256x8.sv
// rtl/ram256x8.sv - 256x8 RAM, asynchronous read, one synchronous write port
module ram256x8 (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_loader_bus.sv
// rtl/mem_loader_bus.sv - CPU memory side with program loader and one I/O address
// Optional CPU write protection of low memory: MEM_WRITE_PROTECT_EN.
module mem_loader_bus
    import mem_sys_pkg::*;
#(
    parameter logic [7:0] IO_ADRS     = IO_ADRS_DEF,
    parameter logic [7:0] PROT_LIMIT  = PROT_LIMIT_DEF,
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_adrs,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    output logic [7:0] cpu_din,
    output logic       cpu_rst_n,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       ld_busy,
    output logic [8:0] ld_count,
    input  logic [7:0] in_port,
    output logic [7:0] out_port,
    output logic       out_strobe,
    output logic       prot_err
);

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [7:0] ptr_q;
    logic [7:0] sync_q [SYNC_STAGES];
    logic       load_entry, ld_beat;
    logic       io_hit, cpu_wr_act, prot_hit, cpu_io_wr, cpu_mem_wr;
    logic       ram_we;
    logic [7:0] ram_waddr, ram_wdata, ram_rdata;
    logic       prot_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid && (ld_last || ptr_q == 8'hFF)) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                ld_busy = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ld_start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign ld_beat    = ld_ready && ld_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= 8'h00;
            ld_count <= 9'd0;
        end else if (load_entry) begin
            ptr_q    <= 8'h00;
            ld_count <= 9'd0;
        end else if (ld_beat) begin
            ptr_q    <= (ptr_q == 8'hFF) ? ptr_q : ptr_q + 8'd1;
            ld_count <= ld_count + 9'd1;
        end
    end

    // CPU leaves reset one edge after RUN is entered and drops on the ld_start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= (state_q == ST_RUN) && !ld_start;
        end
    end

    assign io_hit     = (cpu_adrs == IO_ADRS);
    assign cpu_wr_act = cpu_rst_n && cpu_wr;
    assign prot_hit   = PROT_EN && cpu_wr_act && !io_hit && (cpu_adrs < PROT_LIMIT);
    assign cpu_io_wr  = cpu_wr_act && io_hit;
    assign cpu_mem_wr = cpu_wr_act && !io_hit && !prot_hit;

    // cpu_rst_n is only high in RUN, so the loader and CPU never write together.
    assign ram_we    = ld_beat || cpu_mem_wr;
    assign ram_waddr = (state_q == ST_LOAD) ? ptr_q   : cpu_adrs;
    assign ram_wdata = (state_q == ST_LOAD) ? ld_data : cpu_dout;

    ram256x8 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (cpu_adrs),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_port   <= 8'h00;
            out_strobe <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            out_strobe <= cpu_io_wr;
            if (cpu_io_wr) out_port <= cpu_dout;
            if (prot_hit) prot_err_q <= 1'b1;
        end
    end

    assign prot_err = PROT_EN && prot_err_q;

    always_comb begin
        cpu_din = 8'h00;
        if (cpu_rst_n && cpu_rd) begin
            cpu_din = io_hit ? sync_q[SYNC_STAGES-1] : ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_loader_bus.sv
// tb/tb_mem_loader_bus.sv - directed self-checking bench for mem_loader_bus
module tb_mem_loader_bus;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_adrs, cpu_dout;
    logic       cpu_rd, cpu_wr;
    logic [7:0] cpu_din;
    logic       cpu_rst_n;
    logic       ld_start, ld_valid, ld_last;
    logic [7:0] ld_data;
    logic       ld_ready, ld_busy;
    logic [8:0] ld_count;
    logic [7:0] in_port, out_port;
    logic       out_strobe, prot_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_loader_bus dut (
        .clk(clk), .rst(rst),
        .cpu_adrs(cpu_adrs), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_rst_n(cpu_rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_count(ld_count),
        .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe), .prot_err(prot_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic v, input logic l);
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        cpu_rd   = 1'b1;
        cpu_adrs = a;
        #1;
        check(tag, cpu_din, exp);
        cpu_rd   = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_adrs = a;
        cpu_dout = d;
        tick();
        cpu_wr   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cpu_adrs = 8'h00; cpu_dout = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        in_port = 8'h00;
        tick(); tick();

        // reset state
        check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_ld_busy", ld_busy, 1'b0);
        check("rst_ld_count", ld_count, 9'd0);
        check("rst_out_port", out_port, 8'h00);
        check("rst_out_strobe", out_strobe, 1'b0);
        check("rst_prot_err", prot_err, 1'b0);
        rst = 1'b1;
        tick();
        check("idle_ld_ready", ld_ready, 1'b0);

        // 1: four-byte load with ld_last
        start_load();
        check("t1_ld_ready", ld_ready, 1'b1);
        check("t1_ld_busy", ld_busy, 1'b1);
        beat(8'h01, 1'b1, 1'b0);
        beat(8'h10, 1'b1, 1'b0);
        beat(8'h02, 1'b1, 1'b0);
        beat(8'h20, 1'b1, 1'b1);
        check("t1_ld_count", ld_count, 9'd4);
        check("t1_release_ready", ld_ready, 1'b0);
        check("t1_release_busy", ld_busy, 1'b1);
        check("t1_release_rst_n", cpu_rst_n, 1'b0);
        tick();
        check("t1_run_busy", ld_busy, 1'b0);
        check("t1_edge1_rst_n", cpu_rst_n, 1'b0);
        tick();
        check("t1_edge2_rst_n", cpu_rst_n, 1'b1);
        read_chk("t1_rd0", 8'h00, 8'h01);
        read_chk("t1_rd1", 8'h01, 8'h10);
        read_chk("t1_rd2", 8'h02, 8'h02);
        read_chk("t1_rd3", 8'h03, 8'h20);
        #1 check("t1_din_no_rd", cpu_din, 8'h00);

        // 6a + 2: ld_start in RUN drops CPU reset; toggling ld_valid
        start_load();
        check("t6_rst_n_drop", cpu_rst_n, 1'b0);
        check("t6_ld_ready", ld_ready, 1'b1);
        check("t6_count_clr", ld_count, 9'd0);
        beat(8'hAA, 1'b1, 1'b0);
        beat(8'hFF, 1'b0, 1'b1);
        beat(8'hBB, 1'b1, 1'b0);
        beat(8'hEE, 1'b0, 1'b0);
        check("t2_mid_count", ld_count, 9'd2);
        beat(8'hCC, 1'b1, 1'b1);
        check("t2_ld_count", ld_count, 9'd3);
        tick(); tick();
        check("t2_rst_n", cpu_rst_n, 1'b1);
        read_chk("t2_rd0", 8'h00, 8'hAA);
        read_chk("t2_rd1", 8'h01, 8'hBB);
        read_chk("t2_rd2", 8'h02, 8'hCC);
        read_chk("t2_rd3_kept", 8'h03, 8'h20);

        // 3: 256 beats, no ld_last, auto release at FF
        start_load();
        for (int i = 0; i < 256; i++) begin
            beat(8'(i) ^ 8'h3C, 1'b1, 1'b0);
        end
        check("t3_ld_count", ld_count, 9'd256);
        check("t3_release_ready", ld_ready, 1'b0);
        check("t3_release_busy", ld_busy, 1'b1);
        tick(); tick();
        check("t3_rst_n", cpu_rst_n, 1'b1);
        read_chk("t3_rd00", 8'h00, 8'h3C);
        read_chk("t3_rd80", 8'h80, 8'hBC);
        read_chk("t3_rdFE", 8'hFE, 8'hC2);
        check("t3_memFF", dut.u_ram.mem[255], 8'hC3);

        // 4: I/O address
        read_chk("t4_io_rd0", 8'hFF, 8'h00);
        cpu_write(8'hFF, 8'hA5);
        check("t4_out_port", out_port, 8'hA5);
        check("t4_strobe_hi", out_strobe, 1'b1);
        tick();
        check("t4_strobe_lo", out_strobe, 1'b0);
        check("t4_memFF_kept", dut.u_ram.mem[255], 8'hC3);
        in_port = 8'h3C;
        tick();
        read_chk("t4_in_lat1", 8'hFF, 8'h00);
        tick();
        read_chk("t4_in_lat2", 8'hFF, 8'h3C);

        // 5: write protection
        cpu_write(8'h10, 8'h99);
`ifdef MEM_WRITE_PROTECT_EN
        read_chk("t5_rd10", 8'h10, 8'h2C);
        check("t5_prot_err", prot_err, 1'b1);
        cpu_write(8'h50, 8'h66);
        read_chk("t5_rd50", 8'h50, 8'h66);
        check("t5_prot_sticky", prot_err, 1'b1);
`else
        read_chk("t5_rd10", 8'h10, 8'h99);
        check("t5_prot_err", prot_err, 1'b0);
        cpu_write(8'h50, 8'h66);
        read_chk("t5_rd50", 8'h50, 8'h66);
`endif
        check("t5_strobe_none", out_strobe, 1'b0);

        // 6b: async reset mid-LOAD
        start_load();
        beat(8'h11, 1'b1, 1'b0);
        beat(8'h22, 1'b1, 1'b0);
        #2 rst = 1'b0;
        cpu_rd = 1'b1;
        cpu_adrs = 8'h01;
        #1;
        check("t6_rst_ready", ld_ready, 1'b0);
        check("t6_rst_busy", ld_busy, 1'b0);
        check("t6_rst_count", ld_count, 9'd0);
        check("t6_rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("t6_rst_out_port", out_port, 8'h00);
        check("t6_rst_strobe", out_strobe, 1'b0);
        check("t6_rst_prot", prot_err, 1'b0);
        check("t6_rst_din", cpu_din, 8'h00);
        cpu_rd = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_idle_ready", ld_ready, 1'b0);
        start_load();
        beat(8'h77, 1'b1, 1'b1);
        check("t6_reload_count", ld_count, 9'd1);
        tick(); tick();
        read_chk("t6_rd0", 8'h00, 8'h77);
        read_chk("t6_rd1_kept", 8'h01, 8'h22);
        read_chk("t6_rd2_kept", 8'h02, 8'h3E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
